// File: rtl/pc_redirect_controller.sv
// rtl/pc_redirect_controller.sv - program counter owner with qualified redirect, flush bubbles, stall and halt
//
// Ports:
//   Clk, Rst            clock (rising edge) and asynchronous active-low reset
//   BranchValid         EX holds a real control-flow instruction this cycle
//   PCSrc, PCNew        redirect request and target from branch resolution
//   Stall               load-use hazard, hold PC this cycle
//   Halt                level halt request
//   PC                  registered fetch address
//   PCPlus4             PC + PC_STEP (combinational, wraps modulo 2^32)
//   FetchValid          PC is a valid fetch this cycle
//   FlushIFID/FlushIDEX pipeline register clears during the flush window
//   Halted              controller is halted (left only through reset)
//   Misaligned          sticky: some accepted redirect target had non-zero low bits
//   RedirectCount       accepted redirects, saturating at 16'hFFFF
module pc_redirect_controller #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,               // legal range 1..15
    parameter logic [31:0] PC_STEP      = 32'd4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        BranchValid,
    input  logic        PCSrc,
    input  logic [31:0] PCNew,
    input  logic        Stall,
    input  logic        Halt,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        FlushIFID,
    output logic        FlushIDEX,
    output logic        Halted,
    output logic        Misaligned,
    output logic [15:0] RedirectCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    // Counter is loaded with FLUSH_CYCLES-1 and the FLUSH state is left when it
    // reads zero, which gives exactly FLUSH_CYCLES bubble cycles.
    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [3:0] flush_cnt;
    logic       redirect;

    // Branch resolution raises PCSrc for undecoded selects, so only a
    // qualified request is ever acted on.
    assign redirect = BranchValid & PCSrc;
    assign PCPlus4  = PC + PC_STEP;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state         <= IDLE;
            PC            <= RESET_PC;
            flush_cnt     <= 4'd0;
            FetchValid    <= 1'b0;
            FlushIFID     <= 1'b0;
            FlushIDEX     <= 1'b0;
            Halted        <= 1'b0;
            Misaligned    <= 1'b0;
            RedirectCount <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= RUN;
                    FetchValid <= 1'b1;
                end
                RUN: begin
                    if (redirect) begin
                        // Redirect outranks halt and stall; a coincident stall is dropped.
                        PC <= {PCNew[31:2], 2'b00};
                        if (PCNew[1:0] != 2'b00) begin
                            Misaligned <= 1'b1;
                        end
                        if (RedirectCount != 16'hFFFF) begin
                            RedirectCount <= RedirectCount + 16'd1;
                        end
                        flush_cnt  <= FLUSH_LOAD;
                        state      <= FLUSH;
                        FetchValid <= 1'b0;
                        FlushIFID  <= 1'b1;
                        FlushIDEX  <= 1'b1;
                    end else if (Halt) begin
                        state      <= HALT;
                        FetchValid <= 1'b0;
                        Halted     <= 1'b1;
                    end else if (!Stall) begin
                        PC <= PCPlus4;
                    end
                end
                FLUSH: begin
                    // Requests arriving now come from squashed instructions.
                    if (flush_cnt == 4'd0) begin
                        state      <= RUN;
                        FetchValid <= 1'b1;
                        FlushIFID  <= 1'b0;
                        FlushIDEX  <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
